// File: rtl/cam_ov7670_tx.sv
// OV7670 RGB565 camera emulator: generates vsync/href/px_data test frames (bars, gradient, red, checker).
// Optional CAM_TX_FRAME_TAG_EN: replaces pixel (0,0) with {8'hA5, frame_cnt} to expose dropped/repeated frames.
module cam_ov7670_tx #(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 120,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int V_BP        = 2,
    parameter int V_FP        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       vsync,
    output logic       href,
    output logic [7:0] px_data,
    output logic       frame_done,
    output logic       busy
);

    localparam int P  = 2*H_ACTIVE + H_BLANK;
    localparam int HW = $clog2(P);
    localparam int LW = $clog2(VSYNC_LINES + V_BP + V_ACTIVE + V_FP + 1);
    localparam logic [HW-1:0] H_LAST = HW'(P - 1);
    localparam logic [HW-1:0] H_PIX  = HW'(2*H_ACTIVE);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hcnt;
    logic [LW-1:0]   lcnt, lines_m1;
    logic [1:0]      pat;
    logic            line_end, state_end, frame_end, latch;
    logic            href_d;
    logic [15:0]     xw, yw, bar, word;
    logic [2:0]      bar_sat;
    logic [7:0]      byte_d;

    assign line_end  = (hcnt == H_LAST);
    assign state_end = line_end && (lcnt == lines_m1) && (state != S_IDLE);
    assign frame_end = (state == S_VFP) && state_end;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lines_m1  = '0;
        latch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_VSYNC;
                    latch     = 1'b1;
                end
            end
            S_VSYNC: begin
                lines_m1 = LW'(VSYNC_LINES - 1);
                if (state_end) state_nxt = S_VBP;
            end
            S_VBP: begin
                lines_m1 = LW'(V_BP - 1);
                if (state_end) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                lines_m1 = LW'(V_ACTIVE - 1);
                if (state_end) state_nxt = S_VFP;
            end
            S_VFP: begin
                lines_m1 = LW'(V_FP - 1);
                if (state_end) begin
                    state_nxt = enable ? S_VSYNC : S_IDLE;
                    latch     = enable;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // lcnt restarts at every state change so each state just counts its own lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            lcnt <= '0;
            pat  <= '0;
        end else begin
            if (latch) pat <= pattern_sel;
            if (state == S_IDLE) begin
                hcnt <= '0;
                lcnt <= '0;
            end else begin
                hcnt <= line_end ? '0 : hcnt + HW'(1);
                if (state_end)     lcnt <= '0;
                else if (line_end) lcnt <= lcnt + LW'(1);
            end
        end
    end

`ifdef CAM_TX_FRAME_TAG_EN
    logic [7:0] frame_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           frame_cnt <= '0;
        else if (frame_end) frame_cnt <= frame_cnt + 8'd1;
    end
`endif

    assign href_d = (state == S_ACTIVE) && (hcnt < H_PIX);
    assign xw     = 16'(hcnt[HW-1:1]);
    assign yw     = 16'(lcnt);
    assign bar    = xw / 16'(H_ACTIVE/8);
    assign bar_sat = (bar > 16'd7) ? 3'd7 : bar[2:0];

    always_comb begin
        word = 16'h0000;
        case (pat)
            2'd0: begin
                case (bar_sat)
                    3'd0: word = 16'hFFFF;
                    3'd1: word = 16'hFFE0;
                    3'd2: word = 16'h07FF;
                    3'd3: word = 16'h07E0;
                    3'd4: word = 16'hF81F;
                    3'd5: word = 16'hF800;
                    3'd6: word = 16'h001F;
                    default: word = 16'h0000;
                endcase
            end
            2'd1: word = {xw[7:3], yw[6:1], 5'b00000};
            2'd2: word = 16'hF800;
            default: word = (xw[3] ^ yw[3]) ? 16'hFFFF : 16'h0000;
        endcase
`ifdef CAM_TX_FRAME_TAG_EN
        if (xw == 16'd0 && yw == 16'd0) word = {8'hA5, frame_cnt};
`endif
    end

    assign byte_d = hcnt[0] ? word[7:0] : word[15:8];

    logic unused_ok;
    assign unused_ok = ^{xw[15:8], yw[15:7], yw[0], bar[15:3]};

    // Outputs are registered, so the visible frame trails the FSM by one clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            px_data    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            vsync      <= (state == S_VSYNC);
            href       <= href_d;
            px_data    <= href_d ? byte_d : 8'h00;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_cam_ov7670_tx.sv
// Directed bench for cam_ov7670_tx: reset, colour bars, frame structure, pattern latching, enable drop.
module tb_cam_ov7670_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       vsync, href, frame_done, busy;
    logic [7:0] px_data;

    int checks = 0;
    int failures = 0;

    cam_ov7670_tx dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .vsync(vsync), .href(href), .px_data(px_data),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [1:0] pat, input int x, input int y,
                                               input logic [7:0] tag);
        logic [31:0] xv, yv;
        int b;
        xv = x;
        yv = y;
`ifdef CAM_TX_FRAME_TAG_EN
        if (x == 0 && y == 0) return {8'hA5, tag};
`endif
        case (pat)
            2'd0: begin
                b = x / 20;
                if (b > 7) b = 7;
                case (b)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd1: return {xv[7:3], yv[6:1], 5'b00000};
            2'd2: return 16'hF800;
            default: return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Samples one frame on falling edges, starting at its first vsync cycle, until frame_done.
    // act_kind 1: switch pattern_sel to 3 when line act_line starts; 2: drop enable there.
    task automatic run_frame(input string nm, input logic [1:0] pat, input logic [7:0] tag,
                             input int act_line, input int act_kind);
        int cyc = 0, vs = 0, pulses = 0, width = 0, low = 0;
        int badw = 0, badg = 0, badpx = 0, idlepx = 0;
        bit done = 0;
        logic prev_href = 1'b0;
        logic [15:0] w;
        logic [7:0] eb;
        while (!done && cyc < 45000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({nm, "_first_vsync"}, vsync, 1);
            if (vsync) vs++;
            if (href) begin
                if (!prev_href) begin
                    if (pulses > 0 && low != 16) badg++;
                    width = 0;
                    if (pulses == act_line) begin
                        if (act_kind == 1) pattern_sel = 2'd3;
                        if (act_kind == 2) enable = 1'b0;
                    end
                end
                w  = model_word(pat, width >> 1, pulses, tag);
                eb = width[0] ? w[7:0] : w[15:8];
                if (px_data !== eb) badpx++;
                if (pat == 2'd3 && (width == 16 || width == 17)) begin
                    if (pulses == 0) chk({nm, "_px8_0"}, px_data, 8'hFF);
                    if (pulses == 8) chk({nm, "_px8_8"}, px_data, 8'h00);
                end
                width++;
            end else begin
                if (prev_href) begin
                    if (width != 320) badw++;
                    pulses++;
                    low = 0;
                end
                low++;
                if (px_data !== 8'h00) idlepx++;
            end
            prev_href = href;
            if (frame_done) done = 1;
        end
        chk({nm, "_done_seen"}, done, 1);
        chk({nm, "_vsync_len"}, vs, 1008);
        chk({nm, "_href_pulses"}, pulses, 120);
        chk({nm, "_bad_widths"}, badw, 0);
        chk({nm, "_bad_gaps"}, badg, 0);
        chk({nm, "_bad_pixels"}, badpx, 0);
        chk({nm, "_idle_px_nonzero"}, idlepx, 0);
        chk({nm, "_frame_len"}, cyc, 42672);
    endtask

`ifdef CAM_TX_FRAME_TAG_EN
    localparam logic [7:0] B0_EXP = 8'hA5;
    localparam logic [7:0] B1_EXP = 8'h00;
`else
    localparam logic [7:0] B0_EXP = 8'hFF;
    localparam logic [7:0] B1_EXP = 8'hFF;
`endif

    logic [7:0] line0 [0:319];
    int k;
    int stray;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_vsync", vsync, 0);
        chk("rst_href", href, 0);
        chk("rst_px", px_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Colour bars, first line, with start latency
        pattern_sel = 2'd0;
        enable = 1'b1;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_vsync_lag", vsync, 0);
        @(negedge clk);
        chk("start_vsync", vsync, 1);
        k = 1;
        while (!href && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("href_first_cycle", k, 1681);
        for (int i = 0; i < 320; i++) begin
            line0[i] = px_data;
            @(negedge clk);
        end
        chk("bars_b0", line0[0], B0_EXP);
        chk("bars_b1", line0[1], B1_EXP);
        chk("bars_b2", line0[2], 8'hFF);
        chk("bars_b3", line0[3], 8'hFF);
        chk("bars_b40", line0[40], 8'hFF);
        chk("bars_b41", line0[41], 8'hE0);
        chk("bars_b120", line0[120], 8'h07);
        chk("bars_b121", line0[121], 8'hE0);
        chk("bars_b318", line0[318], 8'h00);
        chk("bars_b319", line0[319], 8'h00);

        // Asynchronous reset in the middle of an active line
        repeat (100) @(negedge clk);
        chk("pre_rst_href", href, 1);
        rst = 1'b0;
        #1;
        chk("midrst_vsync", vsync, 0);
        chk("midrst_href", href, 0);
        chk("midrst_px", px_data, 0);
        chk("midrst_done", frame_done, 0);
        chk("midrst_busy", busy, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Frame 1 solid red with sel switched mid-frame; frame 2 checkerboard, enable dropped at line 50
        pattern_sel = 2'd2;
        enable = 1'b1;
        @(negedge clk);
        chk("f1_busy_pre", busy, 1);
        run_frame("f1", 2'd2, 8'h00, 60, 1);
        chk("f1_busy_at_done", busy, 1);
        run_frame("f2", 2'd3, 8'h01, 50, 2);
        chk("f2_busy_at_done", busy, 0);
        stray = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (vsync || busy || href || frame_done) stray++;
        end
        chk("after_stop_quiet", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_ov7670_tx.md
# cam_ov7670_tx

Pattern-generating OV7670 camera emulator: drives `vsync`, `href` and `px_data` exactly as the camera does in RGB565 mode (two bytes per pixel, high byte first). It feeds the camera-capture path (`cam_read` → `buffer_ram_dp` → VGA) on the board or in simulation without a physical sensor. It provides known, repeatable frames so capture addressing, RGB565→332 conversion and display can be checked end to end.

## Interface
Parameters:
- `H_ACTIVE`, 160: pixels per line.
- `V_ACTIVE`, 120: active lines per frame.
- `H_BLANK`, 16: clocks with `href` low at the end of every line.
- `VSYNC_LINES`, 3: lines with `vsync` high.
- `V_BP`, 2: blank lines after `vsync`.
- `V_FP`, 2: blank lines after the last active line.

Ports:
- `clk` in 1: byte clock; all outputs change on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: run frames while high.
- `pattern_sel` in 2: 0 colour bars, 1 gradient, 2 solid red, 3 checkerboard.
- `vsync` out 1: frame sync, active high.
- `href` out 1: line valid, active high.
- `px_data` out 8: pixel byte.
- `frame_done` out 1: one-cycle pulse on the last cycle of each frame.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Line period:** `P = 2*H_ACTIVE + H_BLANK` clocks (336 at defaults).
- **Counters:** `hcnt` runs 0..P-1 and wraps. `lcnt` counts lines within the current state.
- **FSM states:** IDLE, VSYNC, VBP, ACTIVE, VFP.
- **IDLE → VSYNC:** on a clock where `enable`=1. `pattern_sel` is latched on this transition and held for the whole frame.
- **VSYNC → VBP → ACTIVE → VFP:** each state lasts its line count (`VSYNC_LINES`, `V_BP`, `V_ACTIVE`, `V_FP`), with the transition taken when `hcnt`=P-1 on the last line of the state.
- **End of VFP:**
  - `frame_done`=1 for that cycle.
  - If `enable`=1, go to VSYNC with no idle cycle; `pattern_sel` is re-latched.
  - Otherwise go to IDLE.
- **`enable` dropped mid-frame:** the current frame completes; no truncation.
- **Output levels:**
  - `vsync`=1 only in VSYNC.
  - `href`=1 only in ACTIVE with `hcnt` < 2*H_ACTIVE.
  - `px_data`=0 whenever `href`=0.
- **Pixel addressing:** x = `hcnt`>>1, y = active line index.
  - Even `hcnt` outputs word[15:8]; odd `hcnt` outputs word[7:0].
- **Patterns (RGB565 word):**
  - 0, colour bars: 8 bars of width H_ACTIVE/8, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index = x / (H_ACTIVE/8), saturated at 7.
  - 1, gradient: R = x[7:3], G = y[6:1], B = 0.
  - 2, solid red: F800.
  - 3, checkerboard: FFFF if x[3]^y[3], else 0000.
- **Word-generator arithmetic:** unsigned, 5/6/5 fields truncated, no overflow wrap into neighbouring fields.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, counters 0.
- **Reset mid-frame:** outputs go to 0 immediately (asynchronous). After release, the block restarts from IDLE.
- **Start latency:** `enable` sampled high on edge N → `vsync`=1 after edge N+1.
- **Within the first ACTIVE line:** `href` rises on the same edge that starts the line. `px_data` carries byte 0 in that same cycle.
- **Frame length:** `(VSYNC_LINES+V_BP+V_ACTIVE+V_FP)*P` clocks = 127*336 = 42672 at defaults.
- **Frame pacing:** `frame_done` repeats every 42672 clocks while `enable` stays high.
- **Sampling:** downstream samples on the falling edge of `clk`, or clocks the receiver with inverted `clk` as `pclk`. Data is stable for the full cycle.
- **`busy`:** falls on the edge that enters IDLE.

## Configuration
- **`CAM_TX_FRAME_TAG_EN` defined:**
  - An 8-bit frame counter increments at each `frame_done`, wraps 255→0, and resets to 0.
  - Pixel (0,0) of every frame is replaced by word {8'hA5, frame_cnt}.
  - Lets the bench and the VGA capture detect dropped or repeated frames.
- **Undefined:** no counter; pixel (0,0) follows the selected pattern.

## Test plan
- **Reset:** assert `rst`=0 mid-ACTIVE → `vsync`, `href`, `px_data`, `frame_done`, `busy` all 0 in the same cycle.
- **Frame structure:** `enable`=1 with defaults for one frame →
  - `vsync` high for exactly 1008 clocks;
  - 120 `href` pulses, each 320 clocks wide, separated by 16 low clocks;
  - `frame_done` at clock 42672.
- **Colour bars, first line:** bytes 0..3 = FF,FF,FF,FF; bytes 40..41 = FF,E0; bytes 318..319 = 00,00.
- **Pattern latching:** switch `pattern_sel` 2→3 mid-frame → the whole frame remains F800. The next frame is a checkerboard, with pixel (8,0) = FFFF and pixel (8,8) = 0000.
- **`enable` drop:** drop `enable` at line 50 → the frame completes, `frame_done` pulses, the FSM returns to IDLE, and no further `vsync`.
- **Frame tag (`CAM_TX_FRAME_TAG_EN`):** three back-to-back frames → first two bytes of each frame = A5,00 / A5,01 / A5,02.
